// File: rtl/dds_capture.sv
// dds_capture: waits for an armed trigger on a signed 8-bit sample stream,
// keeps one of every decim+1 valid samples, packs four samples per 32-bit
// word (sample k in byte k mod 4) and hands words to a single-entry output
// register that feeds the USB write FIFO.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | inactive, samples ignored
// S_ARMED   | config shadowed, waiting for the trigger sample
// S_CAPTURE | storing every (decim+1)th valid sample
// S_FLUSH   | length reached with a partial word, waiting to emit it
// S_DONE    | capture complete, holds until arm or abort

module dds_capture #(
   parameter int LEN_WIDTH   = 32,
   parameter int DECIM_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [7:0]             sig,
   input  logic                   sig_valid,
   input  logic                   arm,
   input  logic                   abort,
   input  logic [1:0]             trig_mode,
   input  logic [7:0]             trig_level,
   input  logic [LEN_WIDTH-1:0]   capture_len,
   input  logic [DECIM_WIDTH-1:0] decim,
   output logic [31:0]            usb_wr_data,
   output logic                   usb_wr_valid,
   input  logic                   usb_wr_full,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic [LEN_WIDTH-1:0]   sample_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_CAPTURE, S_FLUSH, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             mode_q, mode_d;
   logic signed [7:0]      level_q, level_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [DECIM_WIDTH-1:0] decim_q, decim_d;
   logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
   logic signed [7:0]      prev_q, prev_d;
   logic [31:0]            pack_q, pack_d;
   logic [LEN_WIDTH-1:0]   count_q, count_d;
   logic [31:0]            out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic                   ovf_q, ovf_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic signed [7:0]      sig_s;
   logic                   accept;
   logic                   out_free;
   logic                   trig_hit;
   logic                   store;
   logic                   last_byte;
   logic [31:0]            word;

   assign sig_s = sig;

   // Trigger qualification against the shadowed mode and level (signed compare).
   always_comb begin
      case (mode_q)
         2'd1:    trig_hit = (prev_q < level_q) && (sig_s >= level_q);
         2'd2:    trig_hit = (prev_q > level_q) && (sig_s <= level_q);
         default: trig_hit = 1'b1;
      endcase
   end

   // Next-state, packing and output-register logic.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      level_d     = level_q;
      len_d       = len_q;
      decim_d     = decim_q;
      dcnt_d      = dcnt_q;
      prev_d      = prev_q;
      pack_d      = pack_q;
      count_d     = count_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      store       = 1'b0;

      // A word leaving on this edge frees the register for a same-cycle load.
      accept   = out_valid_q && !usb_wr_full;
      out_free = !out_valid_q || accept;
      if (accept) out_valid_d = 1'b0;

      if (sig_valid) prev_d = sig_s;

      if (arm) begin
         mode_d  = trig_mode;
         level_d = trig_level;
         len_d   = capture_len;
         decim_d = decim;
         dcnt_d  = '0;
         prev_d  = '0;
         pack_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         state_d = (capture_len == '0) ? S_DONE : S_ARMED;
      end else if (abort) begin
         pack_d  = '0;
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (sig_valid && trig_hit) begin
                  store  = 1'b1;
                  dcnt_d = decim_q;
               end
            end
            S_CAPTURE: begin
               if (sig_valid) begin
                  if (dcnt_q == '0) begin
                     store  = 1'b1;
                     dcnt_d = decim_q;
                  end else begin
                     dcnt_d = dcnt_q - 1'b1;
                  end
               end
            end
            S_FLUSH: begin
               // Unused bytes are already zero: the partial word starts cleared.
               if (out_free) begin
                  out_valid_d = 1'b1;
                  out_data_d  = pack_q;
                  pack_d      = '0;
                  state_d     = S_DONE;
               end
            end
            default: ;
         endcase
      end

      word = pack_q;
      word[{count_q[1:0], 3'b000} +: 8] = sig;
      last_byte = (count_q[1:0] == 2'd3);

      if (store) begin
         if (count_q != len_q) count_d = count_q + 1'b1;
         if (last_byte) begin
            pack_d = '0;
            if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = word;
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            pack_d = word;
         end
         if (count_d == len_q) state_d = last_byte ? S_DONE : S_FLUSH;
         else                  state_d = S_CAPTURE;
      end

      busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE) || (state_d == S_FLUSH);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         mode_q      <= '0;
         level_q     <= '0;
         len_q       <= '0;
         decim_q     <= '0;
         dcnt_q      <= '0;
         prev_q      <= '0;
         pack_q      <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         level_q     <= level_d;
         len_q       <= len_d;
         decim_q     <= decim_d;
         dcnt_q      <= dcnt_d;
         prev_q      <= prev_d;
         pack_q      <= pack_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign usb_wr_data  = out_data_q;
   assign usb_wr_valid = out_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign overflow     = ovf_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_dds_capture.sv
// Self-checking bench for dds_capture: reset values, a table of directed
// captures, hand-written multi-cycle sequences and randomized captures
// compared against a list-based reference model.

module tb_dds_capture;

   localparam int LW = 32;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [7:0]    sig = '0;
   logic          sig_valid = 1'b0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    trig_mode = '0;
   logic [7:0]    trig_level = '0;
   logic [LW-1:0] capture_len = '0;
   logic [DW-1:0] decim = '0;
   logic [31:0]   usb_wr_data;
   logic          usb_wr_valid;
   logic          usb_wr_full = 1'b0;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [LW-1:0] sample_count;

   always #5 clk = ~clk;

   dds_capture #(.LEN_WIDTH(LW), .DECIM_WIDTH(DW)) dut (
      .clk(clk), .resetn(resetn), .sig(sig), .sig_valid(sig_valid),
      .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level),
      .capture_len(capture_len), .decim(decim), .usb_wr_data(usb_wr_data),
      .usb_wr_valid(usb_wr_valid), .usb_wr_full(usb_wr_full), .busy(busy),
      .done(done), .overflow(overflow), .sample_count(sample_count)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] got_q[$];

   // Words that will transfer on the coming rising edge.
   always @(negedge clk)
      if (resetn && usb_wr_valid && !usb_wr_full) got_q.push_back(usb_wr_data);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] s);
      sig_valid = v;
      sig = s;
      tick();
   endtask

   task automatic idle(input int n);
      sig_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Pulse arm with the given config, then scramble the config inputs.
   task automatic do_arm(input logic [1:0] m, input logic [7:0] lvl, input int len,
                         input int dec, input logic v, input logic [7:0] s);
      trig_mode = m;
      trig_level = lvl;
      capture_len = len;
      decim = 16'(dec);
      sig_valid = v;
      sig = s;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      sig_valid = 1'b0;
      trig_mode = 2'($urandom);
      trig_level = 8'($urandom);
      capture_len = $urandom_range(1, 3);
      decim = 16'($urandom_range(0, 3));
   endtask

   typedef struct {
      string        name;
      logic [1:0]   mode;
      logic [7:0]   level;
      int           len;
      int           dec;
      logic [127:0] stim;
      int           nw;
      logic [31:0]  w0;
      logic [31:0]  w1;
   } vec_t;

   vec_t vecs[8];

   logic [7:0]  rs[120];
   logic        rv[120];
   int          vs[$];
   int          kept[$];
   int          base;

   initial begin
      vecs[0] = '{"immediate", 2'd0, 8'h00, 8, 0, 128'h100F0E0D0C0B0A09_0807060504030201, 2, 32'h04030201, 32'h08070605};
      vecs[1] = '{"rising",    2'd1, 8'h0A, 3, 0, 128'h0000000000000000_02011E140C0905FB, 1, 32'h001E140C, 32'h0};
      vecs[2] = '{"falling",   2'd2, 8'h00, 2, 0, 128'h0000000000000000_0A090807FEFF0305, 1, 32'h0000FEFF, 32'h0};
      vecs[3] = '{"decim2",    2'd0, 8'h00, 4, 2, 128'h0F0E0D0C0B0A0908_0706050403020100, 1, 32'h09060300, 32'h0};
      vecs[4] = '{"mode3",     2'd3, 8'h7F, 1, 0, 128'h0000000000000000_0000000000006655, 1, 32'h00000055, 32'h0};
      vecs[5] = '{"rise_eq",   2'd1, 8'h00, 2, 0, 128'h0000000000000000_00000007_03FE0500, 1, 32'h00000703, 32'h0};
      vecs[6] = '{"rise_neg",  2'd1, 8'hFD, 1, 0, 128'h0000000000000000_00000005_FEF6FD01, 1, 32'h000000FE, 32'h0};
      vecs[7] = '{"decim1_5",  2'd0, 8'h00, 5, 1, 128'h1F1E1D1C1B1A1918_1716151413121110, 2, 32'h16141210, 32'h00000018};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", usb_wr_valid, 0);
      check("rst_data", usb_wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_count", sample_count, 0);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // Arm timing, ignored arm-cycle sample, word latency
      do_arm(2'd0, 8'h00, 4, 0, 1'b1, 8'hAA);
      check("arm_busy", busy, 1);
      drive(1'b1, 8'h01);
      check("cnt_after_1", sample_count, 1);
      drive(1'b1, 8'h02);
      drive(1'b1, 8'h03);
      check("no_word_yet", usb_wr_valid, 0);
      drive(1'b1, 8'h04);
      check("w4_valid", usb_wr_valid, 1);
      check("w4_data", usb_wr_data, 32'h04030201);
      check("w4_done", done, 1);
      check("w4_count", sample_count, 4);
      idle(3);

      // Partial word flush timing
      do_arm(2'd0, 8'h00, 3, 0, 1'b0, 8'h00);
      drive(1'b1, 8'h11);
      drive(1'b1, 8'h22);
      drive(1'b1, 8'h33);
      check("flush_busy", busy, 1);
      check("flush_done", done, 0);
      check("flush_nvalid", usb_wr_valid, 0);
      tick();
      check("flush_valid", usb_wr_valid, 1);
      check("flush_data", usb_wr_data, 32'h00332211);
      check("flush_done2", done, 1);
      idle(3);

      // Backpressure and overflow
      usb_wr_full = 1'b1;
      do_arm(2'd0, 8'h00, 12, 0, 1'b0, 8'h00);
      for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i));
      check("bp_valid", usb_wr_valid, 1);
      check("bp_ovf0", overflow, 0);
      for (int i = 5; i <= 12; i++) begin
         drive(1'b1, 8'(i));
         check("bp_stable", usb_wr_data, 32'h04030201);
         if (i == 8) check("bp_ovf_set", overflow, 1);
      end
      check("bp_done", done, 1);
      check("bp_count", sample_count, 12);
      base = got_q.size();
      usb_wr_full = 1'b0;
      idle(5);
      check("bp_xfers", got_q.size() - base, 1);
      if (got_q.size() > base) check("bp_word", got_q[base], 32'h04030201);
      check("bp_ovf_sticky", overflow, 1);

      // Word completing on the cycle the old word is accepted
      usb_wr_full = 1'b1;
      base = got_q.size();
      do_arm(2'd0, 8'h00, 8, 0, 1'b0, 8'h00);
      check("arm_clr_ovf", overflow, 0);
      for (int i = 1; i <= 7; i++) drive(1'b1, 8'(i));
      usb_wr_full = 1'b0;
      drive(1'b1, 8'h08);
      idle(3);
      check("same_cyc_ovf", overflow, 0);
      check("same_cyc_n", got_q.size() - base, 2);
      if (got_q.size() >= base + 2) begin
         check("same_cyc_w0", got_q[base], 32'h04030201);
         check("same_cyc_w1", got_q[base+1], 32'h08070605);
      end

      // Asynchronous reset mid-capture
      usb_wr_full = 1'b1;
      do_arm(2'd0, 8'h00, 20, 0, 1'b0, 8'h00);
      for (int i = 1; i <= 9; i++) drive(1'b1, 8'(i));
      check("pre_rst_ovf", overflow, 1);
      #2;
      resetn = 1'b0;
      #1;
      check("arst_valid", usb_wr_valid, 0);
      check("arst_data", usb_wr_data, 0);
      check("arst_busy", busy, 0);
      check("arst_ovf", overflow, 0);
      check("arst_count", sample_count, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      resetn = 1'b1;
      usb_wr_full = 1'b0;
      base = got_q.size();
      for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom));
      check("post_rst_words", got_q.size() - base, 0);
      check("post_rst_busy", busy, 0);

      // Zero length
      base = got_q.size();
      do_arm(2'd0, 8'h00, 0, 0, 1'b0, 8'h00);
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      for (int i = 0; i < 8; i++) drive(1'b1, 8'(i + 1));
      check("len0_words", got_q.size() - base, 0);
      check("len0_count", sample_count, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_done", done, 0);

      // arm and abort together: arm wins
      trig_mode = 2'd0; capture_len = 4; decim = '0;
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      check("armabort_busy", busy, 1);
      for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i));
      check("armabort_word", usb_wr_data, 32'h04030201);
      check("armabort_done", done, 1);
      idle(3);

      // Abort with a presented word: the word survives
      usb_wr_full = 1'b1;
      base = got_q.size();
      do_arm(2'd0, 8'h00, 8, 0, 1'b0, 8'h00);
      for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_keep_v", usb_wr_valid, 1);
      check("abort_keep_d", usb_wr_data, 32'h04030201);
      usb_wr_full = 1'b0;
      idle(3);
      check("abort_xfer", got_q.size() - base, 1);
      do_arm(2'd0, 8'h00, 4, 0, 1'b0, 8'h00);
      for (int i = 10; i <= 13; i++) drive(1'b1, 8'(i));
      check("rearm_word", usb_wr_data, 32'h0D0C0B0A);
      idle(3);

      // Table-driven captures
      for (int v = 0; v < 8; v++) begin
         base = got_q.size();
         do_arm(vecs[v].mode, vecs[v].level, vecs[v].len, vecs[v].dec, 1'b0, 8'h00);
         for (int i = 0; i < 16; i++) drive(1'b1, vecs[v].stim[8*i +: 8]);
         idle(4);
         check({vecs[v].name, "_nw"}, got_q.size() - base, vecs[v].nw);
         if (got_q.size() > base) check({vecs[v].name, "_w0"}, got_q[base], vecs[v].w0);
         if (vecs[v].nw > 1 && got_q.size() > base + 1)
            check({vecs[v].name, "_w1"}, got_q[base+1], vecs[v].w1);
         check({vecs[v].name, "_done"}, done, 1);
         check({vecs[v].name, "_count"}, sample_count, vecs[v].len);
         check({vecs[v].name, "_ovf"}, overflow, 0);
      end

      // Randomized captures against a list-based model
      for (int r = 0; r < 25; r++) begin
         logic [1:0]  m;
         logic [7:0]  lvl;
         int          len, dec, t, lv, pv, nw;
         logic        hit, complete;
         logic [31:0] expw;
         m = 2'($urandom);
         lvl = 8'($urandom);
         len = $urandom_range(1, 24);
         dec = $urandom_range(0, 3);
         for (int i = 0; i < 120; i++) begin
            rv[i] = ($urandom_range(0, 3) != 0);
            rs[i] = 8'($urandom);
         end
         base = got_q.size();
         do_arm(m, lvl, len, dec, 1'($urandom), 8'($urandom));
         for (int i = 0; i < 120; i++) drive(rv[i], rs[i]);
         idle(4);

         vs.delete();
         for (int i = 0; i < 120; i++) if (rv[i]) vs.push_back(int'($signed(rs[i])));
         lv = int'($signed(lvl));
         t = -1;
         for (int k = 0; k < vs.size() && t < 0; k++) begin
            pv = (k == 0) ? 0 : vs[k-1];
            case (m)
               2'd1:    hit = (pv < lv) && (vs[k] >= lv);
               2'd2:    hit = (pv > lv) && (vs[k] <= lv);
               default: hit = 1'b1;
            endcase
            if (hit) t = k;
         end
         kept.delete();
         if (t >= 0)
            for (int k = t; k < vs.size() && kept.size() < len; k += dec + 1) kept.push_back(vs[k]);
         complete = (kept.size() == len);
         nw = complete ? (len + 3) / 4 : kept.size() / 4;

         check("rnd_nwords", got_q.size() - base, nw);
         for (int w = 0; w < nw && base + w < got_q.size(); w++) begin
            expw = '0;
            for (int b = 0; b < 4; b++)
               if (4*w + b < kept.size()) expw[8*b +: 8] = 8'(kept[4*w + b]);
            check("rnd_word", got_q[base + w], expw);
         end
         check("rnd_done", done, complete);
         check("rnd_busy", busy, !complete);
         check("rnd_count", sample_count, kept.size());
         check("rnd_ovf", overflow, 0);
         abort = 1'b1;
         tick();
         abort = 1'b0;
         idle(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
